// File: rtl/mul_add_seq_pkg.sv
// Shared types and constants for the mul_add_seq shift-add multiply-accumulator.
// Define MUL_ADD_RADIX4_EN to build the radix-4 (two bits per step) datapath.
package mul_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef MUL_ADD_RADIX4_EN
    localparam int RADIX = 4;
`else
    localparam int RADIX = 2;
`endif

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mul_add_seq_step.sv
// One combinational shift-add iteration: {hi, lo} -> {hi', lo'}.
// With MUL_ADD_RADIX4_EN the step consumes two multiplier bits using 3X.
module mul_add_step #(
    parameter int W = 1024
) (
    input  logic [W-1:0] hi,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] xm,
`ifdef MUL_ADD_RADIX4_EN
    input  logic [W+1:0] x3,
`endif
    output logic [W-1:0] hi_n,
    output logic [W-1:0] lo_n
);

`ifdef MUL_ADD_RADIX4_EN
    logic [W+1:0] add;
    logic [W+1:0] s;

    always_comb begin
        add = '0;
        unique case (lo[1:0])
            2'd0: add = '0;
            2'd1: add = {2'b00, xm};
            2'd2: add = {1'b0, xm, 1'b0};
            2'd3: add = x3;
        endcase
        s = {2'b00, hi} + add;
    end

    assign hi_n = s[W+1:2];
    assign lo_n = {s[1:0], lo[W-1:2]};
`else
    logic [W:0] s;

    assign s    = {1'b0, hi} + (lo[0] ? {1'b0, xm} : '0);
    assign hi_n = s[W:1];
    assign lo_n = {s[0], lo[W-1:1]};
`endif

endmodule

// File: rtl/mul_add_seq.sv
// Multi-cycle p = x*y + z with start/done handshake, 2W-bit result {hi, lo}.
// Define MUL_ADD_RADIX4_EN for the radix-4 variant (W must be even).
module mul_add_seq
    import mul_add_pkg::*;
#(
    parameter int W = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic [W-1:0]   z,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int CW    = cnt_w(W);
    localparam int STEPS = W / (RADIX / 2);

    if (W < 2) begin : g_w_small
        $error("mul_add_seq: W must be at least 2");
    end
    if (RADIX == 4 && (W % 2) != 0) begin : g_w_odd
        $error("mul_add_seq: radix-4 build needs even W");
    end

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [W-1:0]  xr;
    logic [W-1:0]  hi_n;
    logic [W-1:0]  lo_n;

`ifdef MUL_ADD_RADIX4_EN
    logic [W+1:0]  x3r;
`endif

    mul_add_step #(.W(W)) u_step (
        .hi   (hi),
        .lo   (lo),
        .xm   (xr),
`ifdef MUL_ADD_RADIX4_EN
        .x3   (x3r),
`endif
        .hi_n (hi_n),
        .lo_n (lo_n)
    );

    assign p = {hi, lo};

    // hi starts at z so the addend rides along with the partial products
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            xr    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef MUL_ADD_RADIX4_EN
            x3r   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        xr    <= x;
                        hi    <= z;
                        lo    <= y;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef MUL_ADD_RADIX4_EN
                        x3r   <= {2'b00, x} + {1'b0, x, 1'b0};
`endif
                    end
                end
                RUN: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(STEPS - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_add_seq.sv
// Self-checking bench for mul_add_seq at W = 8 (radix-2 or MUL_ADD_RADIX4_EN).
// Directed table, hand sequences for reset/held start, then random ops.
module tb_mul_add_seq;

    localparam int W = 8;
`ifdef MUL_ADD_RADIX4_EN
    localparam int LAT = W / 2;
`else
    localparam int LAT = W;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   x = '0;
    logic [W-1:0]   y = '0;
    logic [W-1:0]   z = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_add_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .z     (z),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [15:0] e;
        int          poke;
        string       nm;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [15:0] ref_mac(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [7:0] c);
        return 16'(a) * 16'(b) + 16'(c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [15:0] e,
                          input int poke, input string nm);
        int          dcnt;
        int          dcyc;
        bit          bbad;
        logic [15:0] pd;
        dcnt = 0;
        dcyc = -1;
        bbad = 1'b0;
        pd   = '0;
        x = a;
        y = b;
        z = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        x = 8'($urandom);
        y = 8'($urandom);
        z = 8'($urandom);
        for (int cyc = 1; cyc <= LAT + 2; cyc++) begin
            if (busy !== logic'(cyc <= LAT + 1)) bbad = 1'b1;
            if (done === 1'b1) begin
                dcnt++;
                dcyc = cyc;
                pd   = p;
            end
            if (cyc == LAT + 2) begin
                chk({nm, " held"}, 32'(p), 32'(e));
            end else begin
                start = (cyc == poke);
                if (cyc == poke) begin
                    x = 8'd1;
                    y = 8'd1;
                    z = 8'd0;
                end
                tick();
                start = 1'b0;
            end
        end
        chk({nm, " busy"}, 32'(bbad), 32'd0);
        chk({nm, " done count"}, 32'(dcnt), 32'd1);
        chk({nm, " done cycle"}, 32'(dcyc), 32'(LAT + 1));
        chk({nm, " p"}, 32'(pd), 32'(e));
    endtask

    initial begin
        int d1;
        int d2;
        tbl[0] = '{8'hFF, 8'hFF, 8'hFF, 16'hFF00, 0, "max"};
        tbl[1] = '{8'h00, 8'hAB, 8'h5C, 16'h005C, 0, "zero x"};
        tbl[2] = '{8'd13, 8'd11, 8'd0,  16'h008F, 4, "ignore start"};
        tbl[3] = '{8'h00, 8'h00, 8'h00, 16'h0000, 0, "all zero"};
        tbl[4] = '{8'hFF, 8'hFF, 8'h00, 16'hFE01, 0, "max no z"};
        tbl[5] = '{8'h01, 8'hFF, 8'hFF, 16'h01FE, 0, "unit x"};

        tick();
        tick();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset p", 32'(p), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].e,
                   tbl[i].poke, tbl[i].nm);
        end

        // reset in the middle of a run
        x = 8'd9;
        y = 8'd9;
        z = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst p", 32'(p), 32'd0);

        // reset and start together: start is dropped
        start = 1'b1;
        x = 8'd7;
        y = 8'd7;
        z = 8'd7;
        tick();
        start = 1'b0;
        rst_n = 1'b1;
        chk("rst+start busy", 32'(busy), 32'd0);
        chk("rst+start p", 32'(p), 32'd0);
        tick();
        chk("rst+start idle", 32'(busy), 32'd0);
        run_op(8'd3, 8'd5, 8'd7, 16'h0016, 0, "after reset");

        // start held high across two operations
        d1 = -1;
        d2 = -1;
        x = 8'd2;
        y = 8'd3;
        z = 8'd1;
        start = 1'b1;
        tick();
        x = 8'd4;
        y = 8'd4;
        z = 8'd4;
        for (int cyc = 1; cyc <= 3 * (LAT + 2) && d2 < 0; cyc++) begin
            if (done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    chk("hold op1 p", 32'(p), 32'h0007);
                end else begin
                    d2 = cyc;
                    chk("hold op2 p", 32'(p), 32'h0014);
                end
            end
            if (d1 >= 0 && cyc > d1 + 1) start = 1'b0;
            tick();
        end
        start = 1'b0;
        chk("hold done1 cycle", 32'(d1), 32'(LAT + 1));
        chk("hold done spacing", 32'(d2 - d1), 32'(LAT + 2));
        tick();
        tick();
        tick();

        for (int i = 0; i < 16; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [7:0] rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 8'($urandom);
            run_op(ra, rb, rc, ref_mac(ra, rb, rc), 0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
